// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enable RAM: sequencer state encoding,
// lane parity and byte-enable to bit-mask expansion.
// Helpers work on fixed maximum widths; callers cast to their own widths.
package ram_pkg;

    localparam int MAX_DATA_W = 128;
    localparam int MAX_NB     = 128;
    localparam int MAX_LANE_W = 128;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ram_state_e;

    // Even parity bit of one lane (zero-extended by the caller).
    function automatic logic parity(input logic [MAX_LANE_W-1:0] v);
        return ^v;
    endfunction

    // Expand one enable bit per lane into one enable bit per data bit.
    function automatic logic [MAX_DATA_W-1:0] lane_mask(input logic [MAX_NB-1:0] be,
                                                        input int lane_w);
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < MAX_DATA_W; b++) begin
            m[b] = be[b / lane_w];
        end
        return m;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps every address once after reset or on clr, then
// hands the array over to normal request traffic.
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | writing INIT_VALUE to address cnt, one location per cycle
// RUN   | sweep done, requests may be accepted
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              init_busy,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              run
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    ram_state_e        state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    // State and sweep counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: clr always restarts the sweep from address 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                if (clr) begin
                    cnt_nxt = '0;
                end else if (cnt == LAST_ADDR) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign init_busy  = (state == CLEAR);
    assign sweep_we   = (state == CLEAR);
    assign sweep_addr = cnt;
    assign run        = (state == RUN);

endmodule

// File: rtl/sync_ram_be.sv
// Single-port synchronous RAM with valid/ready requests, per-lane byte
// enables, a one-cycle registered read response and a hardware clear sweep.
// Optional build macro RAM_PARITY_EN adds one even-parity bit per lane and
// flags mismatches on read responses through rsp_perr.
module sync_ram_be
    import ram_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                LANE_W     = 8,
    parameter int                ADDR_W     = 4,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [DATA_W/LANE_W-1:0]   req_be,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_perr,
    output logic                       init_busy
);

    localparam int NB    = DATA_W / LANE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    logic              run;
    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;
    logic              accept, wr_acc, rd_acc;
    logic [DATA_W-1:0] wmask;
    logic [DATA_W-1:0] mem [DEPTH];

    ram_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .init_busy  (init_busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .run        (run)
    );

    // clr blocks acceptance in the same cycle it is seen.
    assign req_ready = run & ~clr;
    assign accept    = req_valid & req_ready;
    assign wr_acc    = accept & req_we;
    assign rd_acc    = accept & ~req_we;
    assign wmask     = DATA_W'(lane_mask(MAX_NB'(req_be), LANE_W));

    // Array write port; sweep and request writes never coincide since
    // requests are only accepted in RUN.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_addr] <= INIT_VALUE;
        end else if (wr_acc) begin
            mem[req_addr] <= (mem[req_addr] & ~wmask) | (req_wdata & wmask);
        end
    end

    // Registered read response; data holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= rd_acc;
            if (rd_acc) begin
                rsp_rdata <= mem[req_addr];
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] wpar;

    function automatic logic [NB-1:0] word_par(input logic [DATA_W-1:0] w);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) begin
            p[i] = parity(MAX_LANE_W'(w[i*LANE_W +: LANE_W]));
        end
        return p;
    endfunction

    assign wpar = word_par(req_wdata);

    // Parity store tracks the data array lane by lane.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            par_mem[sweep_addr] <= word_par(INIT_VALUE);
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) begin
                    par_mem[req_addr][i] <= wpar[i];
                end
            end
        end
    end

    // Error flag accompanies the read response only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_perr <= 1'b0;
        end else begin
            rsp_perr <= rd_acc && (par_mem[req_addr] != word_par(mem[req_addr]));
        end
    end
`else
    assign rsp_perr = 1'b0;
`endif

endmodule

// File: tb/tb_sync_ram_be.sv
// Bench for sync_ram_be (32-bit data, 8-bit lanes, 16 words).
module tb_sync_ram_be;

    localparam int          DATA_W = 32;
    localparam int          LANE_W = 8;
    localparam int          ADDR_W = 4;
    localparam int          NB     = DATA_W / LANE_W;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] INIT   = 32'h0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [3:0]    req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_perr;
    logic          init_busy;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [31:0] m_mem [DEPTH];
    int          left;          // sweep cycles still to go
    logic        exp_valid;
    logic [31:0] exp_rdata;

    sync_ram_be #(
        .DATA_W     (DATA_W),
        .LANE_W     (LANE_W),
        .ADDR_W     (ADDR_W),
        .INIT_VALUE (INIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_perr  (rsp_perr),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fill_init();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT;
    endtask

    // One clock cycle: drive, check combinational outputs, advance the model,
    // then check the registered response after the edge.
    task automatic step(input logic v, input logic we, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] b, input logic c);
        logic acc;
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = b;
        clr       = c;
        #1;
        check("req_ready", req_ready, (left == 0) && !c);
        check("init_busy", init_busy, left != 0);
        acc       = v && (left == 0) && !c;
        exp_valid = acc && !we;
        if (exp_valid) exp_rdata = m_mem[a];
        if (acc && we) begin
            for (int i = 0; i < NB; i++)
                if (b[i]) m_mem[a][i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W];
        end
        if (c) begin
            left = DEPTH;
            fill_init();
        end else if (left > 0) begin
            left--;
        end
        @(posedge clk);
        #1;
        check("rsp_valid", rsp_valid, exp_valid);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_perr", rsp_perr, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        step(1'b1, 1'b1, a, d, b, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0);
    endtask

    // Async reset applied mid-cycle; released shortly after a rising edge so
    // the next step's falling edge is the first cycle of the new sweep.
    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        clr       = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_perr", rsp_perr, 1'b0);
        check("rst_init_busy", init_busy, 1'b1);
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        left      = DEPTH;
        exp_valid = 1'b0;
        exp_rdata = 32'h0;
        fill_init();
    endtask

    initial begin
        apply_reset();

        // sweep length after release
        repeat (15) idle();
        check("busy_at_15", init_busy, 1'b1);
        idle();
        check("ready_at_17", req_ready, 1'b1);

        for (int a = 0; a < DEPTH; a++) rd(4'(a));
        check("lit_init_read", rsp_rdata, 32'h0);

        wr(4'd0, 32'h0000_00FF, 4'hF);
        wr(4'd1, 32'h0000_00F8, 4'hF);
        rd(4'd0);
        check("lit_rd0_ff", rsp_rdata, 32'h0000_00FF);
        rd(4'd1);
        check("lit_rd1_f8", rsp_rdata, 32'h0000_00F8);
        wr(4'd0, 32'h0000_0001, 4'hF);
        rd(4'd0);
        check("lit_rd0_01", rsp_rdata, 32'h0000_0001);

        wr(4'd3, 32'hAABB_CCDD, 4'hF);
        wr(4'd3, 32'h1122_3344, 4'h5);
        wr(4'd3, 32'hDEAD_BEEF, 4'h0);
        rd(4'd3);
        check("lit_lanes", rsp_rdata, 32'hAA22_CC44);

        // clr with a pending write request: not accepted, sweep restarts
        wr(4'd2, 32'h1234_5678, 4'hF);
        rd(4'd2);
        step(1'b1, 1'b1, 4'd2, 32'hFFFF_FFFF, 4'hF, 1'b1);
        check("lit_read_before_clr", rsp_rdata, 32'h1234_5678);
        repeat (DEPTH) idle();
        rd(4'd2);
        check("lit_clr_rd2", rsp_rdata, 32'h0);
        rd(4'd3);
        check("lit_clr_rd3", rsp_rdata, 32'h0);

        // clr during the sweep restarts it
        step(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1);
        repeat (5) idle();
        step(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1);
        repeat (DEPTH) idle();
        check("lit_ready_after_restart", req_ready, 1'b1);

        // reset in the middle of a sweep
        wr(4'd7, 32'h5555_AAAA, 4'hF);
        apply_reset();
        repeat (7) idle();
        apply_reset();
        repeat (DEPTH) idle();
        check("lit_ready_after_midreset", req_ready, 1'b1);
        rd(4'd7);
        check("lit_rd7_after_reset", rsp_rdata, 32'h0);

        // randomized traffic with occasional clr
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 59) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
